// File: rtl/pi_hbridge_ctrl.sv
// pi_hbridge_ctrl: three-stage PI controller (error, P/I terms, shift+clamp)
// driving a direction-aware H-bridge PWM with dead-time on reversals.
module pi_hbridge_ctrl #(
   parameter int DATA_W   = 12,
   parameter int GAIN_W   = 8,
   parameter int SHIFT    = 4,
   parameter int PWM_W    = 8,
   parameter int DEADTIME = 4,
   parameter int INT_W    = DATA_W + GAIN_W + 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   input  logic              sp_valid,
   input  logic [DATA_W-1:0] sp_data,
   input  logic              meas_valid,
   input  logic [DATA_W-1:0] meas_data,
   input  logic [GAIN_W-1:0] kp,
   input  logic [GAIN_W-1:0] ki,
   output logic              pwm_a,
   output logic              pwm_b,
   output logic [PWM_W-1:0]  duty,
   output logic              dir,
   output logic              sat
);

   localparam int ERR_W = DATA_W + 1;
   localparam int P_W   = ERR_W + GAIN_W + 1;
   localparam int SUM_W = INT_W + 1;

   // Integrator limits +/-(2**(INT_W-1)-1) and output limits +/-(2**PWM_W-1)
   localparam logic signed [SUM_W-1:0] I_MAX = {2'b00, {(INT_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] I_MIN = {2'b11, {(INT_W-2){1'b0}}, 1'b1};
   localparam logic signed [SUM_W-1:0] S_MAX = {{(SUM_W-PWM_W){1'b0}}, {PWM_W{1'b1}}};
   localparam logic signed [SUM_W-1:0] S_MIN = {{(SUM_W-PWM_W){1'b1}}, {(PWM_W-1){1'b0}}, 1'b1};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN_A = 2'd1;
   localparam logic [1:0] ST_RUN_B = 2'd2;
   localparam logic [1:0] ST_DEAD  = 2'd3;

   logic [DATA_W-1:0]       sp_q;
   logic signed [ERR_W-1:0] err_q;
   logic                    s1_valid;
   logic                    s2_valid;
   logic signed [P_W-1:0]   p_q;
   logic signed [INT_W-1:0] integ;
   logic [PWM_W-1:0]        mag_next;
   logic                    dir_next;
   logic [PWM_W-1:0]        cnt;
   logic [1:0]              state;

   logic signed [GAIN_W:0]  kp_s;
   logic signed [GAIN_W:0]  ki_s;
   logic signed [P_W-1:0]   p_calc;
   logic signed [P_W-1:0]   i_incr;
   logic signed [SUM_W-1:0] i_sum;
   logic signed [INT_W-1:0] i_clamped;
   logic                    i_hold;
   logic signed [SUM_W-1:0] pi_sum;
   logic signed [SUM_W-1:0] s_shift;
   logic                    s_clip;
   logic [PWM_W-1:0]        s_mag;
   logic                    wrap;

   assign kp_s    = $signed({1'b0, kp});
   assign ki_s    = $signed({1'b0, ki});
   assign p_calc  = P_W'(err_q) * P_W'(kp_s);
   assign i_incr  = P_W'(err_q) * P_W'(ki_s);
   assign i_sum   = SUM_W'(integ) + SUM_W'(i_incr);
   assign i_hold  = sat & (err_q[ERR_W-1] == dir_next);
   assign pi_sum  = SUM_W'(p_q) + SUM_W'(integ);
   assign s_shift = pi_sum >>> SHIFT;
   assign wrap    = &cnt;

   // Saturate the integrator candidate to its symmetric limits
   always_comb begin
      i_clamped = INT_W'(i_sum);
      if (i_sum > I_MAX) begin
         i_clamped = I_MAX[INT_W-1:0];
      end else if (i_sum < I_MIN) begin
         i_clamped = I_MIN[INT_W-1:0];
      end
   end

   // Clamp the shifted PI sum and take its magnitude for the PWM stage
   always_comb begin
      s_clip = (s_shift > S_MAX) || (s_shift < S_MIN);
      s_mag  = s_shift[PWM_W-1:0];
      if (s_clip) begin
         s_mag = {PWM_W{1'b1}};
      end else if (s_shift[SUM_W-1]) begin
         s_mag = PWM_W'(-s_shift);
      end
   end

   // Setpoint register; loads regardless of enable so a host can preload it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sp_q <= '0;
      end else if (sp_valid) begin
         sp_q <= sp_data;
      end
   end

   // Stage 1: signed error against the setpoint held before this cycle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         err_q    <= '0;
      end else if (!enable) begin
         s1_valid <= 1'b0;
      end else begin
         s1_valid <= meas_valid;
         if (meas_valid) begin
            err_q <= $signed({1'b0, sp_q}) - $signed({1'b0, meas_data});
         end
      end
   end

   // Stage 2: proportional product and integrator with anti-windup freeze
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s2_valid <= 1'b0;
         p_q      <= '0;
         integ    <= '0;
      end else if (!enable) begin
         s2_valid <= 1'b0;
         integ    <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            p_q <= p_calc;
            if (!i_hold) begin
               integ <= i_clamped;
            end
         end
      end
   end

   // Stage 3: pending magnitude/direction; a zero result keeps the old direction
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mag_next <= '0;
         dir_next <= 1'b0;
         sat      <= 1'b0;
      end else if (!enable) begin
         mag_next <= '0;
         sat      <= 1'b0;
      end else if (s2_valid) begin
         mag_next <= s_mag;
         sat      <= s_clip;
         if (s_shift != '0) begin
            dir_next <= s_shift[SUM_W-1];
         end
      end
   end

   // Free-running PWM counter, keeps counting while disabled
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Bridge FSM: duty/dir change only at the period boundary, reversals pass through DEAD
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         duty  <= '0;
         dir   <= 1'b0;
      end else if (!enable) begin
         state <= ST_IDLE;
         duty  <= '0;
      end else if (wrap) begin
         duty <= mag_next;
         dir  <= dir_next;
         if (state == ST_IDLE || dir_next == dir) begin
            state <= dir_next ? ST_RUN_B : ST_RUN_A;
         end else begin
            state <= ST_DEAD;
         end
      end else if (state == ST_DEAD && cnt == PWM_W'(DEADTIME - 1)) begin
         state <= dir ? ST_RUN_B : ST_RUN_A;
      end
   end

   assign pwm_a = (state == ST_RUN_A) && (cnt < duty);
   assign pwm_b = (state == ST_RUN_B) && (cnt < duty);

endmodule

// File: tb/tb_pi_hbridge_ctrl.sv
// tb_pi_hbridge_ctrl: directed and randomized scenarios checked against an
// arithmetic model of the PI law and the per-period bridge behaviour.
module tb_pi_hbridge_ctrl;

   localparam int DATA_W   = 12;
   localparam int GAIN_W   = 8;
   localparam int SHIFT    = 4;
   localparam int PWM_W    = 8;
   localparam int DEADTIME = 4;
   localparam int INT_W    = DATA_W + GAIN_W + 4;
   localparam int PWM_MAX  = 255;
   localparam int PERIOD   = 256;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              enable;
   logic              sp_valid;
   logic [DATA_W-1:0] sp_data;
   logic              meas_valid;
   logic [DATA_W-1:0] meas_data;
   logic [GAIN_W-1:0] kp;
   logic [GAIN_W-1:0] ki;
   logic              pwm_a;
   logic              pwm_b;
   logic [PWM_W-1:0]  duty;
   logic              dir;
   logic              sat;
   logic [PWM_W-1:0]  mcnt;

   int     n_checks = 0;
   int     n_fail   = 0;
   longint m_sp;
   longint m_i;
   int     m_mag;
   int     m_duty;
   bit     m_sat;
   bit     m_dirn;
   bit     m_dir;
   bit     m_running;
   bit     m_dead;

   pi_hbridge_ctrl #(
      .DATA_W(DATA_W), .GAIN_W(GAIN_W), .SHIFT(SHIFT),
      .PWM_W(PWM_W), .DEADTIME(DEADTIME), .INT_W(INT_W)
   ) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable),
      .sp_valid(sp_valid), .sp_data(sp_data),
      .meas_valid(meas_valid), .meas_data(meas_data),
      .kp(kp), .ki(ki),
      .pwm_a(pwm_a), .pwm_b(pwm_b), .duty(duty), .dir(dir), .sat(sat)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   // Bench's own period phase: cycles since reset modulo the PWM period
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) mcnt <= '0;
      else          mcnt <= mcnt + 8'd1;
   end

   // Watchdog so the run always ends
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog");
   end

   task automatic model_reset();
      m_sp = 0; m_i = 0; m_mag = 0; m_duty = 0;
      m_sat = 0; m_dirn = 0; m_dir = 0; m_running = 0; m_dead = 0;
   endtask

   task automatic model_sample(input int meas);
      longint err, sum, q, lim;
      lim = (longint'(1) <<< (INT_W - 1)) - 1;
      err = m_sp - longint'(meas);
      if (!(m_sat && ((err < 0) == m_dirn))) begin
         m_i = m_i + longint'(ki) * err;
         if (m_i > lim) m_i = lim;
         else if (m_i < -lim) m_i = -lim;
      end
      sum = longint'(kp) * err + m_i;
      q = sum / (longint'(1) <<< SHIFT);
      if (sum < 0 && q * (longint'(1) <<< SHIFT) != sum) q = q - 1;
      m_sat = (q > PWM_MAX) || (q < -PWM_MAX);
      if (q > PWM_MAX) q = PWM_MAX;
      if (q < -PWM_MAX) q = -PWM_MAX;
      if (q < 0) begin
         m_dirn = 1'b1;
         m_mag  = int'(-q);
      end else begin
         if (q > 0) m_dirn = 1'b0;
         m_mag = int'(q);
      end
   endtask

   task automatic model_period_start();
      if (enable) begin
         m_dead    = m_running && (m_dirn != m_dir);
         m_dir     = m_dirn;
         m_duty    = m_mag;
         m_running = 1'b1;
      end
   endtask

   task automatic step();
      @(negedge clk);
      if (mcnt == 8'd0) model_period_start();
   endtask

   task automatic set_enable(input bit v);
      enable = v;
      if (!v) begin
         m_i = 0; m_mag = 0; m_sat = 0; m_duty = 0; m_running = 0; m_dead = 0;
      end
   endtask

   task automatic clear_ctrl();
      set_enable(1'b0);
      step();
      set_enable(1'b1);
   endtask

   task automatic wait_cnt(input int target, input string tag);
      int k;
      k = 0;
      while (mcnt != 8'(target) && k < 1000) begin
         step();
         k++;
      end
      if (mcnt != 8'(target)) begin
         n_checks++; n_fail++;
         $display("[TB] FAIL %s_wait: counter phase %0d, required %0d", tag, mcnt, target);
      end
   endtask

   task automatic set_sp(input int v);
      sp_data  = 12'(v);
      sp_valid = 1'b1;
      step();
      sp_valid = 1'b0;
      m_sp = v;
   endtask

   task automatic send_sample(input int meas);
      meas_data  = 12'(meas);
      meas_valid = 1'b1;
      step();
      meas_valid = 1'b0;
      repeat (3) step();
      model_sample(meas);
   endtask

   // Checks one full period starting at the next boundary; returns leg high counts
   task automatic check_period(input string tag, output int na, output int nb);
      int e_duty, bad, first_bad, ovl;
      bit e_dir, e_dead, e_run, exp_a, exp_b;
      wait_cnt(0, tag);
      e_duty = m_duty; e_dir = m_dir; e_dead = m_dead; e_run = m_running;
      n_checks++;
      if (duty !== 8'(e_duty)) begin
         n_fail++; $display("[TB] FAIL %s_duty: got %0d, required %0d", tag, duty, e_duty);
      end
      n_checks++;
      if (dir !== e_dir) begin
         n_fail++; $display("[TB] FAIL %s_dir: got %0b, required %0b", tag, dir, e_dir);
      end
      n_checks++;
      if (sat !== m_sat) begin
         n_fail++; $display("[TB] FAIL %s_sat: got %0b, required %0b", tag, sat, m_sat);
      end
      na = 0; nb = 0; bad = 0; first_bad = -1; ovl = 0;
      for (int c = 0; c < PERIOD; c++) begin
         exp_a = e_run && !e_dir && !(e_dead && c < DEADTIME) && (c < e_duty);
         exp_b = e_run &&  e_dir && !(e_dead && c < DEADTIME) && (c < e_duty);
         if (pwm_a !== exp_a || pwm_b !== exp_b) begin
            bad++;
            if (first_bad < 0) first_bad = c;
         end
         if (pwm_a === 1'b1 && pwm_b === 1'b1) ovl++;
         if (pwm_a === 1'b1) na++;
         if (pwm_b === 1'b1) nb++;
         step();
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("[TB] FAIL %s_pattern: %0d wrong cycles (first at cnt %0d), required 0", tag, bad, first_bad);
      end
      n_checks++;
      if (ovl != 0) begin
         n_fail++; $display("[TB] FAIL %s_overlap: both legs high %0d cycles, required 0", tag, ovl);
      end
   endtask

   task automatic test_reset();
      int na, nb;
      reset_n = 1'b0; enable = 1'b0; sp_valid = 1'b0; meas_valid = 1'b0;
      sp_data = '0; meas_data = '0; kp = '0; ki = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({pwm_a, pwm_b, duty, dir, sat} !== 12'd0) begin
         n_fail++; $display("[TB] FAIL reset_outputs: got %b, required all zero", {pwm_a, pwm_b, duty, dir, sat});
      end
      model_reset();
      reset_n = 1'b1;
      step();
      set_enable(1'b1);
      kp = 8'd16; ki = 8'd1;
      set_sp(12'h800);
      wait_cnt(8, "rst");
      send_sample(12'h7F0);
      check_period("rst_pre", na, nb);
      wait_cnt(5, "rst");
      n_checks++;
      if (pwm_a !== 1'b1) begin
         n_fail++; $display("[TB] FAIL rst_leg_before: pwm_a %b, required 1", pwm_a);
      end
      #2 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({pwm_a, pwm_b, duty} !== 10'd0) begin
         n_fail++; $display("[TB] FAIL rst_async: pwm_a %b pwm_b %b duty %0d, required 0 0 0", pwm_a, pwm_b, duty);
      end
      repeat (2) @(negedge clk);
      model_reset();
      reset_n = 1'b1;
      step();
      check_period("rst_idle", na, nb);
      n_checks++;
      if (na != 0 || nb != 0) begin
         n_fail++; $display("[TB] FAIL rst_no_recover: highs a=%0d b=%0d, required 0 0", na, nb);
      end
      kp = 8'd0; ki = 8'd1;
      set_sp(12'h800);
      wait_cnt(8, "rst");
      send_sample(12'h7F0);
      check_period("rst_integ", na, nb);
      n_checks++;
      if (na != 1) begin
         n_fail++; $display("[TB] FAIL rst_integ_zero: pwm_a highs %0d, required 1", na);
      end
   endtask

   task automatic test_p_step();
      int na, nb;
      clear_ctrl();
      kp = 8'd16; ki = 8'd0;
      set_sp(12'h800);
      wait_cnt(8, "pstep");
      send_sample(12'h7F0);
      check_period("pstep", na, nb);
      n_checks++;
      if (na != 16 || nb != 0) begin
         n_fail++; $display("[TB] FAIL pstep_highs: a=%0d b=%0d, required 16 0", na, nb);
      end
   endtask

   task automatic test_integral();
      int na, nb;
      clear_ctrl();
      kp = 8'd0; ki = 8'd1;
      set_sp(12'h800);
      wait_cnt(8, "integ");
      repeat (4) send_sample(12'h7F0);
      check_period("integ4", na, nb);
      n_checks++;
      if (na != 4) begin
         n_fail++; $display("[TB] FAIL integ4_highs: got %0d, required 4", na);
      end
      wait_cnt(8, "integ");
      send_sample(12'h7F0);
      check_period("integ5", na, nb);
      n_checks++;
      if (na != 5) begin
         n_fail++; $display("[TB] FAIL integ5_highs: got %0d, required 5", na);
      end
   endtask

   task automatic test_saturation();
      int na, nb;
      clear_ctrl();
      kp = 8'd255; ki = 8'd1;
      set_sp(12'hFFF);
      wait_cnt(8, "sat");
      repeat (3) send_sample(0);
      n_checks++;
      if (sat !== 1'b1) begin
         n_fail++; $display("[TB] FAIL sat_flag: got %b, required 1", sat);
      end
      check_period("sat", na, nb);
      n_checks++;
      if (na != 255) begin
         n_fail++; $display("[TB] FAIL sat_highs: got %0d, required 255", na);
      end
      kp = 8'd0;
      set_sp(12'h800);
      wait_cnt(8, "sat");
      send_sample(12'h810);
      check_period("sat_frozen", na, nb);
      n_checks++;
      if (na != 254) begin
         n_fail++; $display("[TB] FAIL sat_frozen_highs: got %0d, required 254", na);
      end
   endtask

   task automatic test_reversal();
      int na, nb;
      clear_ctrl();
      kp = 8'd16; ki = 8'd0;
      set_sp(12'h800);
      wait_cnt(8, "rev");
      send_sample(12'h7F0);
      check_period("rev_fwd", na, nb);
      wait_cnt(8, "rev");
      send_sample(12'h810);
      check_period("rev", na, nb);
      n_checks++;
      if (na != 0 || nb != 12) begin
         n_fail++; $display("[TB] FAIL rev_highs: a=%0d b=%0d, required 0 12", na, nb);
      end
   endtask

   task automatic test_disable();
      int na, nb;
      clear_ctrl();
      kp = 8'd16; ki = 8'd1;
      set_sp(12'h800);
      wait_cnt(8, "dis");
      send_sample(12'h700);
      check_period("dis_pre", na, nb);
      wait_cnt(100, "dis");
      n_checks++;
      if (pwm_a !== 1'b1) begin
         n_fail++; $display("[TB] FAIL dis_leg_before: pwm_a %b, required 1", pwm_a);
      end
      set_enable(1'b0);
      step();
      n_checks++;
      if ({pwm_a, pwm_b, duty, sat} !== 11'd0) begin
         n_fail++; $display("[TB] FAIL dis_off: pwm_a %b pwm_b %b duty %0d sat %b, required all 0", pwm_a, pwm_b, duty, sat);
      end
      repeat (5) step();
      set_enable(1'b1);
      wait_cnt(8, "dis");
      send_sample(12'h7F0);
      check_period("dis_re", na, nb);
      n_checks++;
      if (na != 17) begin
         n_fail++; $display("[TB] FAIL dis_integ_cleared: pwm_a highs %0d, required 17", na);
      end
   endtask

   task automatic test_back_to_back();
      int na, nb, meas, new_sp;
      clear_ctrl();
      kp = 8'($urandom_range(1, 40)); ki = 8'd0;
      set_sp(12'h800);
      wait_cnt(8, "b2b");
      for (int k = 0; k < 6; k++) begin
         meas = 2048 + int'($urandom_range(0, 200)) - 100;
         meas_data  = 12'(meas);
         meas_valid = 1'b1;
         if (k == 3) begin
            new_sp   = 2048 + int'($urandom_range(0, 100)) - 50;
            sp_data  = 12'(new_sp);
            sp_valid = 1'b1;
         end
         step();
         model_sample(meas);
         if (k == 3) begin
            sp_valid = 1'b0;
            m_sp = new_sp;
         end
      end
      meas_valid = 1'b0;
      repeat (4) step();
      check_period("b2b", na, nb);
   endtask

   task automatic test_random();
      int na, nb, n, meas;
      for (int r = 0; r < 10; r++) begin
         kp = 8'($urandom_range(0, 40));
         ki = 8'($urandom_range(0, 2));
         if ($urandom_range(0, 1) == 1) set_sp(int'($urandom_range(300, 3800)));
         wait_cnt(8, "rnd");
         n = int'($urandom_range(1, 4));
         for (int k = 0; k < n; k++) begin
            meas = int'(m_sp) + int'($urandom_range(0, 240)) - 120;
            if (meas < 0) meas = 0;
            if (meas > 4095) meas = 4095;
            send_sample(meas);
         end
         n_checks++;
         if (sat !== m_sat) begin
            n_fail++; $display("[TB] FAIL rnd_sat_early: got %b, required %b", sat, m_sat);
         end
         check_period("rnd", na, nb);
      end
   endtask

   // Scenario sequence
   initial begin
      test_reset();
      test_p_step();
      test_integral();
      test_saturation();
      test_reversal();
      test_disable();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
